sa_result_streamer: RTL and testbench

- Drain end of the 10x10 weight-stationary systolic array.
- Detects the array's level-high done, snapshots the full signed result matrix into a local buffer, then streams it out one element per accepted beat.
- Output is a valid/ready stream in row-major order.
- Each element is requantized (arithmetic shift plus saturation) to a narrower output width.
- Frees the array to be reset and restarted while the previous frame is still draining.

---
 rtl/sa_result_streamer.sv | 122 ++++++++++++
 tb/tb_sa_result_streamer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_result_streamer.sv
// Drain end of the NxN systolic array: snapshots the result matrix on the rising edge
// of done_in and streams it out row-major as requantized (shift + saturate) elements.
module sa_result_streamer #(
  parameter int N     = 10,
  parameter int DW    = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    done_in,
  input  logic [N*N*DW-1:0]       res_in,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [OUT_W-1:0] m_data,
  output logic [3:0]              m_row,
  output logic [3:0]              m_col,
  output logic                    m_last,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    sat_flag,
  output logic [7:0]              drop_cnt
);

  localparam int AW = $clog2(N * N);
  localparam logic [3:0] LAST_IDX = 4'(N - 1);
  localparam logic signed [DW-1:0] SAT_HI = DW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [DW-1:0] SAT_LO = DW'(-(2 ** (OUT_W - 1)));

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state;
  logic                 done_q;
  logic [3:0]           row, col;
  logic signed [DW-1:0] frame_buf [N*N];

  logic                 rise, accept;
  logic [AW-1:0]        rd_idx;
  logic signed [DW-1:0] shifted;
  logic                 clamp_hi, clamp_lo;

  assign rise     = done_in & ~done_q;
  assign accept   = m_valid & m_ready;
  assign rd_idx   = AW'(row) * AW'(N) + AW'(col);
  assign shifted  = frame_buf[rd_idx] >>> SHIFT;
  assign clamp_hi = shifted > SAT_HI;
  assign clamp_lo = shifted < SAT_LO;

  assign m_row  = row;
  assign m_col  = col;
  assign m_last = m_valid && (row == LAST_IDX) && (col == LAST_IDX);

  // Data is derived from registered buffer and index, so it is stable across stalls.
  always_comb begin
    m_data = '0;
    if (m_valid) begin
      if (clamp_hi)      m_data = SAT_HI[OUT_W-1:0];
      else if (clamp_lo) m_data = SAT_LO[OUT_W-1:0];
      else               m_data = shifted[OUT_W-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; reset here is synchronous, evaluated only at the clock edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      done_q     <= 1'b0;
      m_valid    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sat_flag   <= 1'b0;
      row        <= '0;
      col        <= '0;
      drop_cnt   <= '0;
    end else begin
      done_q     <= done_in;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state    <= STREAM;
            m_valid  <= 1'b1;
            busy     <= 1'b1;
            sat_flag <= 1'b0;
            row      <= '0;
            col      <= '0;
          end
        end
        STREAM: begin
          // A new frame announced while draining is dropped, even on the final beat.
          if (rise && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          if (accept) begin
            if (clamp_hi || clamp_lo) sat_flag <= 1'b1;
            if (col != LAST_IDX) begin
              col <= col + 4'd1;
            end else if (row != LAST_IDX) begin
              col <= '0;
              row <= row + 4'd1;
            end else begin
              state      <= IDLE;
              m_valid    <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              row        <= '0;
              col        <= '0;
            end
          end
        end
      endcase
    end
  end

  // NOTE: the frame buffer has no reset; its contents only matter after a snapshot,
  // and leaving it unreset lets it map onto plain storage.
  always_ff @(posedge clk) begin
    if (state == IDLE && rise) begin
      for (int i = 0; i < N * N; i++) frame_buf[i] <= res_in[i*DW +: DW];
    end
  end

endmodule

// File: tb/tb_sa_result_streamer.sv
// Randomized self-checking bench for sa_result_streamer: two instances (SHIFT 0 and 2)
// share stimulus and are compared against a frame-level reference model.
module tb_sa_result_streamer;

  localparam int N     = 10;
  localparam int DW    = 16;
  localparam int OUT_W = 8;
  localparam int NN    = N * N;
  localparam int OMAX  = (2 ** (OUT_W - 1)) - 1;
  localparam int OMIN  = -(2 ** (OUT_W - 1));

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic done_in = 1'b0;
  logic m_ready = 1'b0;
  logic [NN*DW-1:0] res_in = '0;

  logic v0, v2, l0, l2, b0, b2, fd0, fd2, s0, s2;
  logic signed [OUT_W-1:0] d0, d2;
  logic [3:0] r0, r2, c0, c2;
  logic [7:0] dc0, dc2;

  sa_result_streamer #(.N(N), .DW(DW), .OUT_W(OUT_W), .SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .done_in(done_in), .res_in(res_in),
    .m_valid(v0), .m_ready(m_ready), .m_data(d0), .m_row(r0), .m_col(c0),
    .m_last(l0), .busy(b0), .frame_done(fd0), .sat_flag(s0), .drop_cnt(dc0)
  );

  sa_result_streamer #(.N(N), .DW(DW), .OUT_W(OUT_W), .SHIFT(2)) u_dut2 (
    .clk(clk), .rst(rst), .done_in(done_in), .res_in(res_in),
    .m_valid(v2), .m_ready(m_ready), .m_data(d2), .m_row(r2), .m_col(c2),
    .m_last(l2), .busy(b2), .frame_done(fd2), .sat_flag(s2), .drop_cnt(dc2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mat  [NN];
  int snap [NN];
  int exp_drop = 0;
  bit exp_sat0 = 1'b0;
  bit exp_sat2 = 1'b0;

  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: floor(v / 2^sh), then clamp to the output range.
  function automatic int scaled(input int v, input int sh);
    int d = 2 ** sh;
    int q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    return q;
  endfunction

  function automatic int exp_elem(input int v, input int sh);
    int q = scaled(v, sh);
    if (q > OMAX) q = OMAX;
    if (q < OMIN) q = OMIN;
    return q;
  endfunction

  function automatic bit clips(input int v, input int sh);
    int q = scaled(v, sh);
    return (q > OMAX) || (q < OMIN);
  endfunction

  task automatic fill(input int pat);
    for (int i = 0; i < NN; i++) begin
      case (pat)
        0:       mat[i] = 10 * (i / N) + (i % N);
        1:       mat[i] = int'($urandom_range(0, 2000)) - 1000;
        2:       mat[i] = int'($urandom_range(0, 65535)) - 32768;
        default: mat[i] = int'($urandom_range(0, 1023)) - 512;
      endcase
    end
    if (pat == 1) begin
      mat[0] = 400; mat[1] = -600; mat[2] = 13; mat[3] = -13; mat[4] = 1000;
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NN; i++) res_in[i*DW +: DW] = DW'(mat[i]);
  endtask

  task automatic take_snapshot();
    for (int i = 0; i < NN; i++) snap[i] = mat[i];
    exp_sat0 = 1'b0;
    exp_sat2 = 1'b0;
  endtask

  task automatic start_frame(input int pat);
    fill(pat);
    pack();
    if (done_in) begin
      done_in = 1'b0;
      tick();
    end
    check("pre_valid", v0, 0);
    check("pre_busy", b0, 0);
    done_in = 1'b1;
    tick();
    take_snapshot();
  endtask

  // Streams the snapshotted frame. ready_mode: 0 always, 1 pattern 1,0,0,1, 2 random.
  task automatic run_frame(input int ready_mode, input int drop_beat, input int rst_beat,
                           input bit isolate, output bit aborted);
    int k = 0;
    int cyc = 0;
    int ds = 0;
    bit rdy;
    aborted = 1'b0;
    if (isolate) begin
      for (int i = 0; i < NN; i++) mat[i] = -1;
      pack();
    end
    while (k < NN) begin
      check("valid", v0, 1);
      check("valid_s2", v2, 1);
      check("busy", b0, 1);
      check("row", r0, k / N);
      check("col", c0, k % N);
      check("row_s2", r2, k / N);
      check("col_s2", c2, k % N);
      check("last", l0, (k == NN - 1) ? 1 : 0);
      check("data_s0", d0, exp_elem(snap[k], 0));
      check("data_s2", d2, exp_elem(snap[k], 2));
      check("sat_s0", s0, exp_sat0);
      check("sat_s2", s2, exp_sat2);
      check("drop", dc0, exp_drop);
      check("fdone_mid", fd0, 0);
      if (k == rst_beat) begin
        rst = 1'b0;
        tick();
        exp_drop = 0;
        check("rst_valid", v0, 0);
        check("rst_busy", b0, 0);
        check("rst_drop", dc0, 0);
        check("rst_fdone", fd0, 0);
        check("rst_sat", s2, 0);
        check("rst_last", l0, 0);
        check("rst_row", r0, 0);
        check("rst_data", d0, 0);
        rst = 1'b1;
        aborted = 1'b1;
        return;
      end
      if (ds == 1) begin
        done_in = 1'b1;
        ds = 2;
        if (exp_drop < 255) exp_drop++;
      end else if (ds == 0 && k == drop_beat) begin
        done_in = 1'b0;
        ds = 1;
      end
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      m_ready = rdy;
      tick();
      cyc++;
      if (rdy) begin
        if (clips(snap[k], 0)) exp_sat0 = 1'b1;
        if (clips(snap[k], 2)) exp_sat2 = 1'b1;
        k++;
      end
      if (cyc > 20 * NN) begin
        check("timeout", 0, 1);
        return;
      end
    end
    check("end_valid", v0, 0);
    check("end_busy", b0, 0);
    check("fdone", fd0, 1);
    check("fdone_s2", fd2, 1);
    check("end_last", l0, 0);
    check("end_row", r0, 0);
    check("end_col", c0, 0);
    check("end_sat_s0", s0, exp_sat0);
    check("end_sat_s2", s2, exp_sat2);
    check("end_drop", dc0, exp_drop);
    check("end_drop_s2", dc2, exp_drop);
    m_ready = 1'b0;
    tick();
    check("fdone_pulse", fd0, 0);
    check("idle_valid", v0, 0);
    check("hold_sat_s0", s0, exp_sat0);
    check("hold_sat_s2", s2, exp_sat2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ab;
    rst = 1'b0;
    repeat (2) tick();
    check("reset_valid", v0, 0);
    check("reset_busy", b0, 0);
    check("reset_fdone", fd0, 0);
    check("reset_sat", s0, 0);
    check("reset_drop", dc0, 0);
    check("reset_row", r0, 0);
    check("reset_col", c0, 0);
    check("reset_data", d0, 0);
    check("reset_last", l0, 0);
    rst = 1'b1;
    tick();
    check("idle_no_rise", v0, 0);

    start_frame(0); run_frame(0, -1, -1, 1'b0, ab);   // ordered ramp, full rate
    start_frame(1); run_frame(1, -1, -1, 1'b0, ab);   // saturation, 1,0,0,1 backpressure
    start_frame(2); run_frame(2, 40, -1, 1'b0, ab);   // overlap drop at beat 40
    start_frame(3); run_frame(0, -1, -1, 1'b1, ab);   // input isolation after snapshot
    start_frame(3); run_frame(0, 98, -1, 1'b0, ab);   // rise on the final accept
    check("drop_two", dc0, 2);

    start_frame(2); run_frame(0, -1, 57, 1'b0, ab);   // reset mid-stream at beat 57
    check("aborted", ab, 1);
    fill(3);
    pack();
    tick();
    take_snapshot();
    check("restart_valid", v0, 1);
    run_frame(2, -1, -1, 1'b0, ab);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
